// File: rtl/prog_loader_pkg.sv
// ============================================================================
// prog_loader_pkg : shared word size and loader FSM state encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  localparam int WORD_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_LEN  = 3'd2,
    ST_LOAD     = 3'd3,
    ST_FLUSH    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : streams an {addr, len, data...} frame into processor memory
// Rev 1.0
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int word_size = WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [word_size-1:0] byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic [word_size-1:0] address_bus,
  output logic [word_size-1:0] data_bus,
  output logic                 ext_write,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [word_size-1:0]   r_ptr;
  logic [word_size-1:0]   w_ptr_nxt;
  logic [word_size-1:0]   r_cnt;
  logic [word_size-1:0]   w_cnt_nxt;
  logic [word_size-1:0]   w_addr_nxt;
  logic [word_size-1:0]   w_data_nxt;
  logic                   w_ext_write_nxt;
  logic                   w_cpu_rst_nxt;
  logic                   w_done_nxt;
  logic                   w_err_nxt;
  logic                   w_accept;

  assign busy       = (r_state != ST_IDLE);
  assign byte_ready = (r_state == ST_GET_ADDR) || (r_state == ST_GET_LEN) ||
                      (r_state == ST_LOAD);
  assign w_accept   = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      address_bus <= '0;
      data_bus    <= '0;
      ext_write   <= 1'b0;
      cpu_rst     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      address_bus <= w_addr_nxt;
      data_bus    <= w_data_nxt;
      ext_write   <= w_ext_write_nxt;
      cpu_rst     <= w_cpu_rst_nxt;
      done        <= w_done_nxt;
      err         <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = address_bus;
    w_data_nxt      = data_bus;
    w_ext_write_nxt = 1'b0;
    w_cpu_rst_nxt   = cpu_rst;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;

    // Abort wins over any byte offered on the same edge, so nothing new is written.
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt   = ST_IDLE;
      w_err_nxt     = 1'b1;
      w_cpu_rst_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt   = ST_GET_ADDR;
            w_cpu_rst_nxt = 1'b0;
          end
        end
        ST_GET_ADDR: begin
          if (w_accept) begin
            w_ptr_nxt   = byte_in;
            w_state_nxt = ST_GET_LEN;
          end
        end
        ST_GET_LEN: begin
          if (w_accept) begin
            w_cnt_nxt   = byte_in;
            w_state_nxt = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            w_ext_write_nxt = 1'b1;
            w_addr_nxt      = r_ptr;
            w_data_nxt      = byte_in;
            w_ptr_nxt       = r_ptr + word_size'(1);
            w_cnt_nxt       = r_cnt - word_size'(1);
            // A length of zero wraps through all values, giving 2**word_size bytes.
            if (r_cnt == word_size'(1)) begin
              w_state_nxt = ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          w_state_nxt   = ST_IDLE;
          w_cpu_rst_nxt = 1'b1;
          w_done_nxt    = 1'b1;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : randomized frame-level checks of prog_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_ready;
  logic [7:0] address_bus;
  logic [7:0] data_bus;
  logic       ext_write;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_seen = 0;
  int wr_exp  = 0;
  logic [7:0] data_q[$];

  prog_loader #(.word_size(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .address_bus(address_bus),
    .data_bus   (data_bus),
    .ext_write  (ext_write),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ext_write === 1'b1) wr_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ext_write"}, ext_write, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_byte_ready"}, byte_ready, 0);
    chk({tag, "_address_bus"}, address_bus, 0);
    chk({tag, "_data_bus"}, data_bus, 0);
  endtask

  // Offers one byte until accepted, then checks the strobe in the following cycle.
  task automatic send_byte(input logic [7:0] b, input bit is_data, input logic [7:0] addr,
                           output bit ok);
    bit rdy;
    byte_in    = b;
    byte_valid = 1'b1;
    ok         = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      rdy = byte_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    byte_valid = 1'b0;
    if (!ok) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    chk("wr_strobe", ext_write, is_data);
    if (is_data) begin
      chk("wr_addr", address_bus, addr);
      chk("wr_data", data_bus, b);
      chk("done_early", done, 0);
      wr_exp++;
    end
  endtask

  // gap: 0 none, 1 alternate, 2 random. abort_at/rst_at: data index or -1.
  task automatic run_frame(input logic [7:0] base, input int n, input int gap,
                           input int abort_at, input int rst_at);
    bit         ok;
    int         a;
    int         snap;
    logic [7:0] d;
    logic [7:0] len;
    len = 8'(n % 256);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_cpu_rst", cpu_rst, 0);
    chk("start_busy", busy, 1);
    send_byte(base, 1'b0, 8'h00, ok);
    if (!ok) return;
    send_byte(len, 1'b0, 8'h00, ok);
    if (!ok) return;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        byte_in    = 8'($urandom);
        byte_valid = 1'b1;
        abort      = 1'b1;
        tick();
        abort      = 1'b0;
        byte_valid = 1'b0;
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 0);
        chk("abort_cpu_rst", cpu_rst, 0);
        chk("abort_no_write", ext_write, 0);
        tick();
        chk("abort_err_pulse", err, 0);
        chk("abort_cpu_rst_hold", cpu_rst, 0);
        return;
      end
      if (i == rst_at) begin
        tick();
        snap = wr_seen;
        rst  = 1'b0;
        #1;
        check_reset_values("rst_mid");
        tick();
        tick();
        check_reset_values("rst_hold");
        chk("rst_no_write", wr_seen, snap);
        rst = 1'b1;
        tick();
        return;
      end
      d = (data_q.size() > 0) ? data_q.pop_front() : 8'($urandom);
      a = (int'(base) + i) % 256;
      send_byte(d, 1'b1, a[7:0], ok);
      if (!ok) return;
      if (i != n - 1) begin
        if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
          tick();
          chk("gap_no_write", ext_write, 0);
        end
      end
    end
    tick();
    chk("end_done", done, 1);
    chk("end_cpu_rst", cpu_rst, 1);
    chk("end_busy", busy, 0);
    chk("end_no_write", ext_write, 0);
    tick();
    chk("done_pulse", done, 0);
    chk("cpu_rst_hold", cpu_rst, 1);
  endtask

  initial begin
    int n;
    int ab;
    #1;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b1;
    tick();
    chk("post_reset_cpu_rst", cpu_rst, 0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_err", err, 0);

    data_q = '{8'hA1, 8'hA2, 8'hA3};
    run_frame(8'h10, 3, 0, -1, -1);
    data_q = '{8'h01, 8'h02, 8'h03};
    run_frame(8'hFE, 3, 0, -1, -1);
    run_frame(8'h00, 256, 0, -1, -1);
    run_frame(8'h40, 4, 1, -1, -1);
    run_frame(8'h20, 4, 0, 1, -1);
    run_frame(8'h30, 5, 0, -1, 2);
    run_frame(8'h30, 5, 2, -1, -1);

    for (int f = 0; f < 12; f++) begin
      n  = int'($urandom_range(1, 24));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_frame(8'($urandom), n, 2, ab, -1);
    end

    tick();
    chk("total_writes", wr_seen, wr_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
